// File: rtl/fwd_hazard_pkg.sv
// Shared types and helpers for the forwarding/hazard scoreboard.
package fwd_hazard_pkg;

    // Widest register address the scoreboard entries can hold.
    localparam int SB_RD_W    = 8;
    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic               we;
        logic [SB_RD_W-1:0] rd;
        logic               is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Priority match of one source operand against every scoreboard entry;
// the youngest (lowest index) writer wins.
module fwd_src_match
    import fwd_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 2,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = sel_width(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0]      sb_i,
    input  logic      [REG_ADDR_W-1:0] src_i,
    output logic                       hit_o,
    output logic      [SEL_W-1:0]      stage_o,
    output logic                       hazard_o
);

    always_comb begin
        hit_o    = 1'b0;
        stage_o  = '0;
        hazard_o = 1'b0;
        // Walk oldest to youngest so the youngest match overrides.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (sb_i[k].we && (sb_i[k].rd == SB_RD_W'(src_i)) && (src_i != '0)) begin
                hit_o    = 1'b1;
                stage_o  = SEL_W'(k + 1);
                hazard_o = sb_i[k].is_load && ((k + 1) <= LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Scoreboard-based forwarding select and load-use stall unit.
// Optional performance counters are enabled with FWD_HAZARD_PERF_EN.
module fwd_hazard_scoreboard
    import fwd_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 2,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = sel_width(DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic                          id_we,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_is_load,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
    input  logic                          flush,
    output logic                          stall,
    output logic                          issue,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [31:0]                   perf_stall_cnt,
    output logic [31:0]                   perf_fwd_cnt
`endif
);

    if (REG_ADDR_W > SB_RD_W) begin : g_width_check
        $error("REG_ADDR_W exceeds scoreboard rd width");
    end

    sb_entry_t [DEPTH-1:0]              sb_q, sb_d;
    logic      [NUM_SRC-1:0]            hit, hazard;
    logic      [NUM_SRC-1:0][SEL_W-1:0] stage;
    logic      [NUM_SRC-1:0][SEL_W-1:0] fwd_sel_q, fwd_sel_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_match #(
            .REG_ADDR_W (REG_ADDR_W),
            .DEPTH      (DEPTH),
            .LOAD_LAT   (LOAD_LAT),
            .SEL_W      (SEL_W)
        ) u_match (
            .sb_i     (sb_q),
            .src_i    (id_src[i*REG_ADDR_W +: REG_ADDR_W]),
            .hit_o    (hit[i]),
            .stage_o  (stage[i]),
            .hazard_o (hazard[i])
        );
    end

    assign stall = id_valid & ~flush & (|hazard);
    assign issue = id_valid & ~stall & ~flush;

    always_comb begin
        sb_d    = sb_q;
        sb_d[0] = SB_BUBBLE;
        if (issue) begin
            sb_d[0].we      = id_we;
            sb_d[0].rd      = SB_RD_W'(id_rd);
            sb_d[0].is_load = id_is_load;
        end
        // Flush kills the EX instruction before it can shift into stage 1.
        for (int k = 1; k < DEPTH; k++) begin
            sb_d[k] = (k == 1 && flush) ? SB_BUBBLE : sb_q[k-1];
        end
    end

    always_comb begin
        fwd_sel_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            fwd_sel_d[i] = (issue && hit[i]) ? stage[i] : SEL_W'(FWD_SEL_RF);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q      <= '0;
            fwd_sel_q <= '0;
        end else begin
            sb_q      <= sb_d;
            fwd_sel_q <= fwd_sel_d;
        end
    end

    assign fwd_sel = fwd_sel_q;

`ifdef FWD_HAZARD_PERF_EN
    localparam int CNT_W = $clog2(NUM_SRC + 1);

    logic [31:0]      perf_stall_cnt_q, perf_stall_cnt_d;
    logic [31:0]      perf_fwd_cnt_q, perf_fwd_cnt_d;
    logic [CNT_W-1:0] fwd_nz;
    logic [32:0]      fwd_sum;

    always_comb begin
        fwd_nz = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (fwd_sel_d[i] != '0) fwd_nz = fwd_nz + CNT_W'(1);
        end
        fwd_sum          = {1'b0, perf_fwd_cnt_q} + 33'(fwd_nz);
        perf_fwd_cnt_d   = fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
        perf_stall_cnt_d = perf_stall_cnt_q;
        if (stall && perf_stall_cnt_q != 32'hFFFF_FFFF)
            perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt_q <= '0;
            perf_fwd_cnt_q   <= '0;
        end else begin
            perf_stall_cnt_q <= perf_stall_cnt_d;
            perf_fwd_cnt_q   <= perf_fwd_cnt_d;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_q;
    assign perf_fwd_cnt   = perf_fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed vector bench for fwd_hazard_scoreboard (default and wide configs).
module tb_fwd_hazard_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       v, we, ld, fl;
    logic [4:0] rd;
    logic [9:0] src;
    logic       stall, issue;
    logic [3:0] fwd;

    logic        v2, we2, ld2, fl2;
    logic [4:0]  rd2;
    logic [14:0] src2;
    logic        stall2, issue2;
    logic [8:0]  fwd2;

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] psc, pfc, psc2, pfc2;
`endif

    fwd_hazard_scoreboard dut (
        .clk(clk), .reset(reset), .id_valid(v), .id_we(we), .id_rd(rd),
        .id_is_load(ld), .id_src(src), .flush(fl),
        .stall(stall), .issue(issue), .fwd_sel(fwd)
`ifdef FWD_HAZARD_PERF_EN
        , .perf_stall_cnt(psc), .perf_fwd_cnt(pfc)
`endif
    );

    fwd_hazard_scoreboard #(.REG_ADDR_W(5), .NUM_SRC(3), .DEPTH(4), .LOAD_LAT(2)) dut2 (
        .clk(clk), .reset(reset), .id_valid(v2), .id_we(we2), .id_rd(rd2),
        .id_is_load(ld2), .id_src(src2), .flush(fl2),
        .stall(stall2), .issue(issue2), .fwd_sel(fwd2)
`ifdef FWD_HAZARD_PERF_EN
        , .perf_stall_cnt(psc2), .perf_fwd_cnt(pfc2)
`endif
    );

    typedef struct {
        logic       v, we, ld, fl;
        logic [4:0] rd, s0, s1;
        logic       st, is;
        logic [3:0] fs;
    } vec_t;

    vec_t tv[$];
    int total = 0;
    int bad   = 0;

    task automatic add(input logic v_, we_, input logic [4:0] rd_, input logic ld_,
                       input logic [4:0] s0_, s1_, input logic fl_,
                       input logic st_, is_, input logic [3:0] fs_);
        vec_t t;
        t.v = v_; t.we = we_; t.rd = rd_; t.ld = ld_; t.s0 = s0_; t.s1 = s1_;
        t.fl = fl_; t.st = st_; t.is = is_; t.fs = fs_;
        tv.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        v = 0; we = 0; rd = 0; ld = 0; src = 0; fl = 0;
    endtask

    initial begin
        int n;
        idle();
        v2 = 0; we2 = 0; rd2 = 0; ld2 = 0; src2 = 0; fl2 = 0;
        reset = 1;

        //   v we rd ld s0 s1 fl  st is fs
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 4'h0);
        add(1, 1, 3, 0, 1, 2, 0,  0, 1, 4'h0); // ADD r3
        add(1, 1, 6, 0, 3, 0, 0,  0, 1, 4'h0); // SUB r3,r0
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 4'h1); // op0=1
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 4'h0);
        add(1, 1, 5, 0, 0, 0, 0,  0, 1, 4'h0); // ADD r5
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 4'h0); // NOP
        add(1, 0, 0, 0, 5, 1, 0,  0, 1, 4'h0); // use r5
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 4'h2); // op0=2
        add(1, 1, 5, 0, 0, 0, 0,  0, 1, 4'h0); // ADD r5
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 4'h0);
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 4'h0);
        add(1, 0, 0, 0, 5, 0, 0,  0, 1, 4'h0); // use r5, out of window
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 4'h0);
        add(1, 1, 7, 1, 0, 0, 0,  0, 1, 4'h0); // LW r7
        add(1, 0, 0, 0, 7, 0, 0,  1, 0, 4'h0); // load-use stall
        add(1, 0, 0, 0, 7, 0, 0,  0, 1, 4'h0);
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 4'h2);
        add(1, 1, 4, 0, 0, 0, 0,  0, 1, 4'h0); // ADD r4
        add(1, 1, 4, 0, 0, 0, 0,  0, 1, 4'h0); // ADD r4
        add(1, 0, 0, 0, 4, 4, 0,  0, 1, 4'h0);
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 4'h5); // youngest on both ops
        add(1, 1, 0, 0, 0, 0, 0,  0, 1, 4'h0); // write r0
        add(1, 0, 0, 0, 0, 0, 0,  0, 1, 4'h0);
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 4'h0);
        add(1, 1, 8, 1, 0, 0, 0,  0, 1, 4'h0); // LW r8
        add(1, 0, 0, 0, 8, 0, 1,  0, 0, 4'h0); // flush over hazard
        add(1, 0, 0, 0, 8, 0, 0,  0, 1, 4'h0); // LW killed
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 4'h0);
        add(1, 1,10, 0, 0, 0, 0,  0, 1, 4'h0); // ADD r10
        add(1, 1,10, 1, 0, 0, 0,  0, 1, 4'h0); // LW r10
        add(1, 0, 0, 0, 1,10, 0,  1, 0, 4'h0); // younger load stalls
        add(1, 0, 0, 0, 1,10, 0,  0, 1, 4'h0);
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 4'h8); // op1=2
        add(1, 1,12, 0, 0, 0, 0,  0, 1, 4'h0); // ADD r12
        add(0, 0, 0, 0, 0, 0, 1,  0, 0, 4'h0); // flush kills it in EX
        add(1, 0, 0, 0,12, 0, 0,  0, 1, 4'h0);
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 4'h0);

        tick();
        tick();
        @(negedge clk);
        chk("reset_fwd", 32'(fwd), 32'h0);
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_fwd2", 32'(fwd2), 32'h0);
        tick();
        reset = 0;

        for (int i = 0; i < tv.size(); i++) begin
            v = tv[i].v; we = tv[i].we; rd = tv[i].rd; ld = tv[i].ld;
            src = {tv[i].s1, tv[i].s0}; fl = tv[i].fl;
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tv[i].st));
            chk($sformatf("v%0d_issue", i), 32'(issue), 32'(tv[i].is));
            chk($sformatf("v%0d_fwd", i), 32'(fwd), 32'(tv[i].fs));
            tick();
        end

        // Reset in flight discards the pending writer.
        idle(); v = 1; we = 1; rd = 11;
        tick();
        idle(); reset = 1;
        tick();
        reset = 0; v = 1; src = {5'd0, 5'd11};
        @(negedge clk);
        chk("rst_mid_stall", 32'(stall), 32'h0);
        chk("rst_mid_issue", 32'(issue), 32'h1);
        tick();
        idle();
        @(negedge clk);
        chk("rst_mid_fwd", 32'(fwd), 32'h0);
        tick();

        // Wide config: LW r9 then consumer, LOAD_LAT=2.
        v2 = 1; we2 = 1; rd2 = 9; ld2 = 1; src2 = 0;
        @(negedge clk);
        chk("w_lw_issue", 32'(issue2), 32'h1);
        tick();
        we2 = 0; rd2 = 0; ld2 = 0; src2 = {5'd2, 5'd1, 5'd9};
        n = 0;
        @(negedge clk);
        while (stall2 && n < 8) begin
            n++;
            tick();
            @(negedge clk);
        end
        chk("w_stall_cycles", 32'(n), 32'd2);
        chk("w_issue", 32'(issue2), 32'h1);
        tick();
        v2 = 0; src2 = 0;
        @(negedge clk);
        chk("w_fwd", 32'(fwd2), 32'h3);
        tick();
        @(negedge clk);
        chk("w_fwd_clear", 32'(fwd2), 32'h0);
`ifdef FWD_HAZARD_PERF_EN
        chk("w_perf_stall", psc2, 32'd2);
        chk("w_perf_fwd", pfc2, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
- Parametrised successor to the fixed 2-stage, 2-operand forwarding unit.
- Tracks in-flight register writers internally in a shift-register scoreboard.
- Produces registered per-operand forward selects, aligned with the instruction in EX, for NUM_SRC operands over DEPTH post-EX stages.
- Detects load-use hazards and drives the ID stall; sits between the ID/EX pipeline register and the EX operand muxes.

Parameters:
- REG_ADDR_W, 5: register address width.
- NUM_SRC, 2: source operands per instruction.
- DEPTH, 2: forwardable stages after EX (1 = EX/MEM, 2 = MEM/WB, ...); minimum 1.
- LOAD_LAT, 1: a load's result can first be forwarded from stage LOAD_LAT+1; range 0..DEPTH-1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  instruction in ID requests issue to EX.
- id_we  in  1  ID instruction writes a register.
- id_rd  in  REG_ADDR_W  ID destination register.
- id_is_load  in  1  ID instruction is a load.
- id_src  in  NUM_SRC*REG_ADDR_W  ID source registers; operand i at [i*REG_ADDR_W +: REG_ADDR_W].
- flush  in  1  kill the instruction in ID and the one in EX.
- stall  out  1  combinational; hold PC and IF/ID, insert bubble.
- issue  out  1  combinational; id_valid & ~stall & ~flush.
- fwd_sel  out  NUM_SRC*SEL_W  registered; SEL_W = $clog2(DEPTH+1); 0 = register file, k = stage k.

Behaviour:
- Scoreboard: entries e[0..DEPTH-1] = {we, rd, is_load}; e[0] is the instruction now in EX.
- Every cycle: e[k+1] <= e[k]; e[0] <= issue ? {id_we, id_rd, id_is_load} : bubble (we=0).
- Flush: e[0] <= bubble and e[1] <= bubble. A flush therefore kills the EX-stage instruction before it shifts on.
- Match per operand i: entry k matches if e[k].we & e[k].rd == src_i & src_i != 0. The lowest k wins (youngest writer).
- Hazard: the youngest match is a load with k+1 <= LOAD_LAT -> stall=1. This holds even if an older, ready match exists.
- stall = id_valid & ~flush & (OR of hazards over all operands). flush has priority: when flush=1, stall=0 and issue=0.
- fwd_sel update on issue: operand i <= (youngest match k exists and k+1 <= DEPTH) ? k+1 : 0.
- fwd_sel when no issue (stall, flush or idle): all fields <= 0.
- Latency: fwd_sel is valid one cycle after issue, i.e. in the cycle the consumer is in EX.
- A writer that has left stage DEPTH is read from the register file; same-cycle WB-to-ID bypass is the register file's job.
- Reset: all entries become bubbles and fwd_sel = 0. stall and issue are then determined only by inputs (stall=0 with an empty scoreboard).
- Reset mid-operation discards all in-flight tracking.
- Writes to r0 are tracked but never match.
- LOAD_LAT=0: loads never stall.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_fwd_cnt[31:0], both cleared by reset.
- perf_stall_cnt increments each cycle stall=1.
- perf_fwd_cnt increments by the number of nonzero fwd_sel fields written on issue.
- Both counters saturate at 32'hFFFF_FFFF.
- Undefined: no ports, no counter logic.

Decomposition:
- Package fwd_hazard_pkg holds:
  - typedef sb_entry_t {we, rd, is_load};
  - FWD_SEL_RF = 0;
  - the function sel_width(depth) returning $clog2(depth+1).
- Sub-module fwd_src_match: one operand's priority match over all entries, outputting hit, stage index and load-hazard. Instantiated NUM_SRC times via generate.

Test Plan:
- Defaults; issue ADD r3; next cycle issue SUB src r3,r0 -> fwd_sel op0=1, op1=0, stall=0.
- ADD r5, then NOP, then consumer of r5 -> op0=2. With one more NOP -> op0=0.
- LW r7 then consumer of r7 (LOAD_LAT=1) -> stall=1 for exactly 1 cycle, then issue with op0=2.
- ADD r4 then ADD r4 then consumer of r4 -> op0=1 (youngest wins). Consumer of r0 after write to r0 -> 0.
- flush asserted with id_valid=1 and a pending load hazard -> stall=0, issue=0, next fwd_sel=0, e[0] and e[1] cleared.
- NUM_SRC=3, DEPTH=4, LOAD_LAT=2: LW r9 then consumer of r9 -> stall 2 cycles, then op=3. With FWD_HAZARD_PERF_EN, perf_stall_cnt=2 and perf_fwd_cnt=1.
